// File: rtl/shifter_operand_pipe.sv
// rtl/shifter_operand_pipe.sv - two-stage ARM shifter-operand (Val2) unit with carry-out
//
// Purpose: computes the ARM operand-2 value and shifter carry-out for three
// operand forms: 12-bit memory offset, rotated 8-bit immediate, and Rm shifted
// by an immediate or by Rs[7:0]. Includes ARM boundary cases such as LSR/ASR #0,
// RRX and shift amounts of width or more. A valid/ready pipeline with two stages
// lets the consumer stall without losing operands.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand bundle handshake
//   mem_mode, imm       form select (mem_mode has priority)
//   c_in                current C flag
//   val_rm, val_rs      Rm value; Rs value (only [7:0] used)
//   shift_operand       instruction bits [11:0]
//   out_valid/out_ready result handshake
//   out_value           operand-2 value
//   out_carry           shifter carry-out
//   out_illegal         register-shift encoding with bit 7 set
module shifter_operand_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mem_mode,
    input  logic             imm,
    input  logic             c_in,
    input  logic [WIDTH-1:0] val_rm,
    input  logic [WIDTH-1:0] val_rs,
    input  logic [11:0]      shift_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_carry,
    output logic             out_illegal
);
    localparam int AW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        M_MEM = 2'd0,
        M_IMM = 2'd1,
        M_ISH = 2'd2,
        M_RSH = 2'd3
    } mode_t;

    // Only the low byte of Rs is a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^val_rs[WIDTH-1:8];

    // Decode (feeds stage 1)
    mode_t            d_mode;
    logic [WIDTH-1:0] d_src;
    logic [7:0]       d_amt;
    logic             d_ill;

    always_comb begin
        d_mode = M_RSH;
        d_src  = val_rm;
        d_amt  = val_rs[7:0];
        d_ill  = 1'b0;
        if (mem_mode) begin
            d_mode = M_MEM;
            d_src  = WIDTH'(shift_operand);
            d_amt  = '0;
        end else if (imm) begin
            // Rotate amount is twice the 4-bit field; it always stays below WIDTH.
            d_mode = M_IMM;
            d_src  = WIDTH'(shift_operand[7:0]);
            d_amt  = {3'b000, shift_operand[11:8], 1'b0};
        end else if (!shift_operand[4]) begin
            d_mode = M_ISH;
            d_amt  = {3'b000, shift_operand[11:7]};
        end else if (shift_operand[7]) begin
            d_ill = 1'b1;
            d_amt = '0;
        end
    end

    // Handshake
    logic s1_v, s2_v;
    logic s1_adv, s2_adv;

    assign s2_adv    = s1_v & (~s2_v | out_ready);
    assign s1_adv    = ~s1_v | s2_adv;
    assign in_ready  = ~rst & s1_adv;
    assign out_valid = s2_v;

    // Stage 1 registers
    mode_t            s1_mode;
    logic [1:0]       s1_typ;
    logic [7:0]       s1_amt;
    logic [WIDTH-1:0] s1_src;
    logic             s1_cin;
    logic             s1_ill;

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_mode <= d_mode;
            s1_typ  <= shift_operand[6:5];
            s1_amt  <= d_amt;
            s1_src  <= d_src;
            s1_cin  <= c_in;
            s1_ill  <= d_ill;
        end
    end

    // Stage 2 combinational shifter. The extended shifts carry one extra bit so
    // the last bit shifted out falls into a fixed position; an amount equal to
    // WIDTH then yields value 0 and the correct edge bit as carry for free.
    logic [31:0]          n_w;
    logic [AW-1:0]        rot;
    logic [WIDTH:0]       lsl_ext;
    logic [WIDTH:0]       lsr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [WIDTH-1:0]     rot_v;
    logic                 sign;
    logic [WIDTH-1:0]     c_value;
    logic                 c_carry;

    assign n_w     = 32'(s1_amt);
    assign rot     = n_w[AW-1:0];
    assign lsl_ext = {1'b0, s1_src} << s1_amt;
    assign lsr_ext = {s1_src, 1'b0} >> s1_amt;
    assign asr_ext = $signed({s1_src, 1'b0}) >>> s1_amt;
    assign rot_v   = WIDTH'({s1_src, s1_src} >> rot);
    assign sign    = s1_src[WIDTH-1];

    always_comb begin
        c_value = '0;
        c_carry = s1_cin;
        if (!s1_ill) begin
            case (s1_mode)
                M_MEM: c_value = s1_src;
                M_IMM: begin
                    c_value = rot_v;
                    if (s1_amt != 8'd0) c_carry = rot_v[WIDTH-1];
                end
                M_ISH: begin
                    if (s1_amt == 8'd0) begin
                        // Amount 0 encodes LSL #0, LSR #32, ASR #32 and RRX.
                        case (s1_typ)
                            2'b00: c_value = s1_src;
                            2'b01: c_carry = sign;
                            2'b10: begin
                                c_value = {WIDTH{sign}};
                                c_carry = sign;
                            end
                            default: begin
                                c_value = {s1_cin, s1_src[WIDTH-1:1]};
                                c_carry = s1_src[0];
                            end
                        endcase
                    end else begin
                        case (s1_typ)
                            2'b00: begin
                                c_value = lsl_ext[WIDTH-1:0];
                                c_carry = lsl_ext[WIDTH];
                            end
                            2'b01: begin
                                c_value = lsr_ext[WIDTH:1];
                                c_carry = lsr_ext[0];
                            end
                            2'b10: begin
                                c_value = asr_ext[WIDTH:1];
                                c_carry = asr_ext[0];
                            end
                            default: begin
                                c_value = rot_v;
                                c_carry = rot_v[WIDTH-1];
                            end
                        endcase
                    end
                end
                M_RSH: begin
                    if (s1_amt == 8'd0) begin
                        c_value = s1_src;
                    end else begin
                        case (s1_typ)
                            2'b00: begin
                                c_carry = 1'b0;
                                if (n_w <= WIDTH) begin
                                    c_value = lsl_ext[WIDTH-1:0];
                                    c_carry = lsl_ext[WIDTH];
                                end
                            end
                            2'b01: begin
                                c_carry = 1'b0;
                                if (n_w <= WIDTH) begin
                                    c_value = lsr_ext[WIDTH:1];
                                    c_carry = lsr_ext[0];
                                end
                            end
                            2'b10: begin
                                if (n_w < WIDTH) begin
                                    c_value = asr_ext[WIDTH:1];
                                    c_carry = asr_ext[0];
                                end else begin
                                    c_value = {WIDTH{sign}};
                                    c_carry = sign;
                                end
                            end
                            default: begin
                                // Multiples of WIDTH rotate back to Rm but still
                                // report bit WIDTH-1 as the carry.
                                if (rot == '0) begin
                                    c_value = s1_src;
                                    c_carry = sign;
                                end else begin
                                    c_value = rot_v;
                                    c_carry = rot_v[WIDTH-1];
                                end
                            end
                        endcase
                    end
                end
                default: c_value = '0;
            endcase
        end
    end

    // Valid bits and stage 2 result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            out_value   <= '0;
            out_carry   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            if (s1_adv) s1_v <= in_valid;
            if (s2_adv) begin
                s2_v        <= 1'b1;
                out_value   <= c_value;
                out_carry   <= c_carry;
                out_illegal <= s1_ill;
            end else if (out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// tb/tb_shifter_operand_pipe.sv - scoreboard bench for shifter_operand_pipe
module tb_shifter_operand_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_mode = 1'b0;
    logic        imm = 1'b0;
    logic        c_in = 1'b0;
    logic [31:0] val_rm = '0;
    logic [31:0] val_rs = '0;
    logic [11:0] shift_operand = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_value;
    logic        out_carry;
    logic        out_illegal;

    shifter_operand_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_mode(mem_mode), .imm(imm), .c_in(c_in), .val_rm(val_rm),
        .val_rs(val_rs), .shift_operand(shift_operand), .out_valid(out_valid),
        .out_ready(out_ready), .out_value(out_value), .out_carry(out_carry),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic        c;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rmode = 0;    // 0: out_ready high, 1: random, 2: held low

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic ill, input logic c, input logic [31:0] v);
        exp_t e;
        e.ill = ill; e.c = c; e.v = v;
        return e;
    endfunction

    // Reference: every non-zero shift is performed one bit at a time, carry being
    // the most recent bit that left (or, for rotates, the new top bit).
    function automatic exp_t model(input logic m, input logic im, input logic cin,
                                   input logic [31:0] rm, input logic [31:0] rs,
                                   input logic [11:0] so);
        exp_t e;
        int n;
        logic [31:0] v;
        logic c;
        logic [1:0] typ;
        typ = so[6:5];
        e.ill = 1'b0;
        if (m) begin
            e.v = {20'b0, so}; e.c = cin;
        end else if (im) begin
            n = 2 * int'(so[11:8]);
            v = {24'b0, so[7:0]};
            c = cin;
            for (int k = 0; k < n; k++) begin
                v = {v[0], v[31:1]};
                c = v[31];
            end
            e.v = v; e.c = c;
        end else if (so[4] && so[7]) begin
            e.ill = 1'b1; e.v = '0; e.c = cin;
        end else begin
            n = so[4] ? int'(rs[7:0]) : int'(so[11:7]);
            if (n == 0 && !so[4]) begin
                case (typ)
                    2'b00: begin e.v = rm; e.c = cin; end
                    2'b01: begin e.v = '0; e.c = rm[31]; end
                    2'b10: begin e.v = {32{rm[31]}}; e.c = rm[31]; end
                    default: begin e.v = {cin, rm[31:1]}; e.c = rm[0]; end
                endcase
            end else if (n == 0) begin
                e.v = rm; e.c = cin;
            end else begin
                v = rm;
                c = cin;
                for (int k = 0; k < n; k++) begin
                    case (typ)
                        2'b00: begin c = v[31]; v = {v[30:0], 1'b0}; end
                        2'b01: begin c = v[0];  v = {1'b0, v[31:1]}; end
                        2'b10: begin c = v[0];  v = {v[31], v[31:1]}; end
                        default: begin v = {v[0], v[31:1]}; c = v[31]; end
                    endcase
                end
                e.v = v; e.c = c;
            end
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic m, input logic im, input logic cin,
                        input logic [31:0] rm, input logic [31:0] rs,
                        input logic [11:0] so, input exp_t e);
        bit done;
        done = 0;
        mem_mode = m; imm = im; c_in = cin; val_rm = rm; val_rs = rs;
        shift_operand = so; in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 34'(in_ready), 34'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic m, im, cin;
        logic [31:0] rm, rs;
        logic [11:0] so;
        m   = ($urandom_range(0, 7) == 0);
        im  = ($urandom_range(0, 3) == 0);
        cin = 1'($urandom);
        rm  = $urandom;
        so  = 12'($urandom);
        case ($urandom_range(0, 5))
            0: rs = {$urandom_range(0, 255), 8'd0};
            1: rs = 32'd31;
            2: rs = 32'd32;
            3: rs = 32'd33;
            4: rs = 32'd64;
            default: rs = $urandom;
        endcase
        send(m, im, cin, rm, rs, so, model(m, im, cin, rm, rs, so));
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !out_valid) ok = 1;
        end
        check("drain", 34'(q.size()), 34'(0));
    endtask

    always begin
        @(posedge clk);
        #2;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare the head of the scoreboard every cycle a result is shown,
    // so a stalled result is checked for stability too.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_result", {out_illegal, out_carry, out_value}, 34'h0);
                if ({out_illegal, out_carry, out_value} == 34'h0) begin
                    miscompares++;
                    $display("FAIL unexpected_result: out_valid with empty scoreboard at %0t", $time);
                end
            end else begin
                check("result", {out_illegal, out_carry, out_value}, q[0]);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", 34'(in_ready), 34'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 34'(out_valid), 34'(0));
        check("rst_outputs", {out_illegal, out_carry, out_value}, 34'h0);

        // Immediate rotate
        send(0, 1, 0, 32'h0, 32'h0, 12'h4FF, mk(0, 1, 32'hFF000000));
        send(0, 1, 1, 32'h0, 32'h0, 12'h0FF, mk(0, 1, 32'h000000FF));
        // Immediate-shift boundaries
        send(0, 0, 1, 32'h80000001, 32'h0, 12'h020, mk(0, 1, 32'h00000000));
        send(0, 0, 1, 32'h80000001, 32'h0, 12'h040, mk(0, 1, 32'hFFFFFFFF));
        send(0, 0, 1, 32'h80000001, 32'h0, 12'h060, mk(0, 1, 32'hC0000000));
        send(0, 0, 1, 32'h80000001, 32'h0, 12'h080, mk(0, 1, 32'h00000002));
        // Register shifts
        send(0, 0, 1, 32'h000000F0, 32'd32, 12'h010, mk(0, 0, 32'h00000000));
        send(0, 0, 1, 32'h000000F0, 32'd4,  12'h030, mk(0, 0, 32'h0000000F));
        send(0, 0, 1, 32'h000000F0, 32'd33, 12'h030, mk(0, 0, 32'h00000000));
        send(0, 0, 1, 32'h000000F0, 32'd64, 12'h070, mk(0, 0, 32'h000000F0));
        send(0, 0, 1, 32'h000000F0, 32'd4,  12'h070, mk(0, 0, 32'h0000000F));
        send(0, 0, 1, 32'h000000F0, 32'd0,  12'h070, mk(0, 1, 32'h000000F0));
        // Mem mode and illegal
        send(1, 1, 1, 32'h12345678, 32'h0, 12'hABC, mk(0, 1, 32'h00000ABC));
        send(0, 0, 1, 32'h12345678, 32'h0, 12'h090, mk(1, 1, 32'h00000000));
        wait_drain();

        // Backpressure: in_ready must fall after exactly two acceptances
        rmode = 2;
        @(posedge clk);
        #1;
        send(0, 0, 0, 32'h1, 32'h0, 12'h080, mk(0, 0, 32'h2));
        send(0, 0, 0, 32'h3, 32'h0, 12'h100, mk(0, 0, 32'hC));
        mem_mode = 1'b1; imm = 1'b0; shift_operand = 12'h555; c_in = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_full", 34'(in_ready), 34'(0));
        fork
            send(1, 0, 0, 32'h0, 32'h0, 12'h555, mk(0, 0, 32'h555));
            begin
                repeat (3) @(posedge clk);
                rmode = 0;
            end
        join
        wait_drain();

        // Five-bundle stream with out_ready low for four cycles
        fork
            for (int i = 0; i < 5; i++) send_rand();
            begin
                repeat (2) @(posedge clk);
                rmode = 2;
                repeat (4) @(posedge clk);
                rmode = 0;
            end
        join
        wait_drain();

        // Random traffic with random backpressure
        rmode = 1;
        for (int i = 0; i < 300; i++) send_rand();
        rmode = 0;
        wait_drain();

        // Reset mid-flight, with a bundle offered during the reset cycle
        send_rand();
        send_rand();
        rst = 1'b1;
        mem_mode = 1'b1; shift_operand = 12'h777; in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_mid_reset", 34'(in_ready), 34'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        check("mid_rst_out_valid", 34'(out_valid), 34'(0));
        check("mid_rst_out_value", 34'(out_value), 34'(0));
        // Post-reset latency: nothing after one edge, result after two
        send(0, 1, 0, 32'h0, 32'h0, 12'h1FF, mk(0, 1, 32'hC000003F));
        @(negedge clk);
        check("latency_e1", 34'(out_valid), 34'(0));
        @(negedge clk);
        check("latency_e2", 34'(out_valid), 34'(1));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
